// File: rtl/sdram_pkg.sv
// Shared definitions for the GW2AR-18 embedded SDRAM controller: command
// encodings, FSM states, mode-register value and address field layout.
package sdram_pkg;

    localparam int BANK_W  = 2;
    localparam int ROW_W   = 11;
    localparam int COL_W   = 8;
    localparam int ADDR_W  = BANK_W + ROW_W + COL_W;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int CAS_LAT = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INH   = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // Burst length 1, sequential, CAS latency 2, programmed burst
    localparam logic [ROW_W-1:0] MODE_REG = 11'h020;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK,
        ST_PWRUP,
        ST_PRE_ALL,
        ST_REF1,
        ST_REF2,
        ST_MRS,
        ST_IDLE,
        ST_ACT,
        ST_RW,
        ST_RD_WAIT,
        ST_RECOV,
        ST_REF
    } state_t;

    typedef struct packed {
        logic              we;
        logic [BANK_W-1:0] ba;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } sdram_req_t;

    // Column address with A10 set, selecting auto-precharge
    function automatic logic [ROW_W-1:0] col_addr(input logic [COL_W-1:0] col);
        return {1'b1, {(ROW_W-1-COL_W){1'b0}}, col};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter: counts while enabled, pulses wrap on
// the last count and restarts from zero; clr holds it at zero.
module sdram_refresh_timer #(
    parameter int LIMIT = 1900
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/sdram_ctrl.sv
// Single-port closed-page controller for the GW2AR-18 embedded 2M x 32 SDRAM.
// Define SDRAM_FAST_INIT_EN for a short power-up wait and refresh interval.
module sdram_ctrl
    import sdram_pkg::*;
#(
    parameter int PWRUP_CYCLES   = 25000,
    parameter int REFRESH_CYCLES = 1900,
    parameter int T_RP           = 2,
    parameter int T_RCD          = 2,
    parameter int T_RFC          = 8,
    parameter int T_MRD          = 2,
    parameter int T_WR           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_ba,
    output logic [ROW_W-1:0]  sdram_a,
    output logic [BE_W-1:0]   sdram_dqm,
    inout  wire  [DATA_W-1:0] sdram_dq
);

`ifdef SDRAM_FAST_INIT_EN
    localparam int PWRUP_N   = 16;
    localparam int REFRESH_N = 64;
`else
    localparam int PWRUP_N   = PWRUP_CYCLES;
    localparam int REFRESH_N = REFRESH_CYCLES;
`endif

    localparam int CNT_W = 16;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cnt_done;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] dq_out;
    logic              dq_oe;
    logic              ref_pending;
    logic              ref_wrap;
    sdram_req_t        cur;

    assign cnt_done = (wait_cnt == '0);
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_dq = dq_oe ? dq_out : 'z;

    // Interval restarts from zero each time initialisation completes
    sdram_refresh_timer #(.LIMIT(REFRESH_N)) u_ref_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!ready),
        .en    (ready),
        .wrap  (ref_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !pll_lock) begin
            state       <= ST_WAIT_LOCK;
            wait_cnt    <= '0;
            cmd         <= CMD_INH;
            sdram_cke   <= 1'b0;
            sdram_ba    <= '0;
            sdram_a     <= '0;
            sdram_dqm   <= '1;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            ready       <= 1'b0;
            ack         <= 1'b0;
            rdata       <= '0;
            ref_pending <= 1'b0;
            cur         <= '0;
        end else begin
            cmd <= CMD_NOP;
            ack <= 1'b0;
            if (ref_wrap)
                ref_pending <= 1'b1;
            // States below only override the counter once it reaches zero
            if (!cnt_done)
                wait_cnt <= wait_cnt - 1'b1;

            case (state)
                ST_WAIT_LOCK: begin
                    sdram_cke <= 1'b1;
                    wait_cnt  <= CNT_W'(PWRUP_N - 1);
                    state     <= ST_PWRUP;
                end
                ST_PWRUP: if (cnt_done) begin
                    cmd      <= CMD_PRE;
                    sdram_a  <= col_addr('0);
                    wait_cnt <= CNT_W'(T_RP - 1);
                    state    <= ST_PRE_ALL;
                end
                ST_PRE_ALL: if (cnt_done) begin
                    cmd      <= CMD_REF;
                    wait_cnt <= CNT_W'(T_RFC - 1);
                    state    <= ST_REF1;
                end
                ST_REF1: if (cnt_done) begin
                    cmd      <= CMD_REF;
                    wait_cnt <= CNT_W'(T_RFC - 1);
                    state    <= ST_REF2;
                end
                ST_REF2: if (cnt_done) begin
                    cmd      <= CMD_MRS;
                    sdram_ba <= '0;
                    sdram_a  <= MODE_REG;
                    wait_cnt <= CNT_W'(T_MRD - 1);
                    state    <= ST_MRS;
                end
                ST_MRS: if (cnt_done) begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    // A wrap in this very cycle also beats a waiting request
                    if (ref_pending || ref_wrap) begin
                        cmd         <= CMD_REF;
                        ref_pending <= 1'b0;
                        wait_cnt    <= CNT_W'(T_RFC - 1);
                        state       <= ST_REF;
                    end else if (req) begin
                        cur.we    <= we;
                        cur.ba    <= addr[ADDR_W-1 -: BANK_W];
                        cur.col   <= addr[COL_W-1:0];
                        cur.wdata <= wdata;
                        cur.be    <= be;
                        cmd       <= CMD_ACT;
                        sdram_ba  <= addr[ADDR_W-1 -: BANK_W];
                        sdram_a   <= addr[COL_W +: ROW_W];
                        wait_cnt  <= CNT_W'(T_RCD - 1);
                        state     <= ST_ACT;
                    end
                end
                ST_ACT: if (cnt_done) begin
                    sdram_ba <= cur.ba;
                    sdram_a  <= col_addr(cur.col);
                    state    <= ST_RW;
                    if (cur.we) begin
                        cmd       <= CMD_WRITE;
                        sdram_dqm <= ~cur.be;
                        dq_out    <= cur.wdata;
                        dq_oe     <= 1'b1;
                        ack       <= 1'b1;
                    end else begin
                        cmd       <= CMD_READ;
                        sdram_dqm <= '0;
                    end
                end
                ST_RW: begin
                    dq_oe <= 1'b0;
                    if (cur.we) begin
                        sdram_dqm <= '1;
                        wait_cnt  <= CNT_W'(T_WR + T_RP - 2);
                        state     <= ST_RECOV;
                    end else begin
                        wait_cnt <= CNT_W'(CAS_LAT - 1);
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: if (cnt_done) begin
                    rdata     <= sdram_dq;
                    ack       <= 1'b1;
                    sdram_dqm <= '1;
                    wait_cnt  <= '0;
                    state     <= ST_RECOV;
                end
                ST_RECOV: if (cnt_done) state <= ST_IDLE;
                ST_REF:   if (cnt_done) state <= ST_IDLE;
                default:  state <= ST_WAIT_LOCK;
            endcase
        end
    end

endmodule
